div_bcd_convert: RTL and testbench
==================================

DIV_BCD_CONVERT -- requirements
Module: div_bcd_convert

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the quotient and remainder inputs.
REQ-002 Parameter DIGITS, default 3: BCD digits per result; 10^DIGITS SHALL exceed 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 done  input  1  completion level from the upstream repeated-subtraction divider; it may stay high for many cycles.
REQ-006 quotient  input  WIDTH  divider quotient, stable while done is high.
REQ-007 remainder  input  WIDTH  divider remainder, stable while done is high.
REQ-008 q_bcd  output  4*DIGITS  packed BCD quotient; most-significant digit in the top nibble.
REQ-009 r_bcd  output  4*DIGITS  packed BCD remainder; same packing as q_bcd.
REQ-010 bcd_valid  output  1  one-cycle pulse marking new q_bcd/r_bcd.
REQ-011 busy  output  1  high while a conversion is in progress.

Function
REQ-012 The block SHALL register done into done_d every cycle.
REQ-013 A rising edge SHALL be recognised at a clock edge where done=1 and done_d=0.
REQ-014 FSM states SHALL be IDLE, SHIFT and OUT.
- IDLE->SHIFT on a recognised rising edge.
- SHIFT->OUT after exactly WIDTH shift cycles.
- OUT->IDLE unconditionally.
REQ-015 On the IDLE->SHIFT edge, the block SHALL latch quotient and remainder into two WIDTH-bit shift registers.
- Same edge: clear both DIGITS-nibble BCD accumulators and set the iteration counter to 0.
REQ-016 Each SHIFT cycle SHALL perform one double-dabble step on both operands in parallel.
- First, every accumulator nibble >=5 gets +3.
- Then {accumulator, shift register} shifts left by 1.
- Then the counter increments.
REQ-017 Counter width SHALL be ceil(log2(WIDTH+1)) bits; SHIFT SHALL exit when the counter reaches WIDTH-1 on the shifting edge.
- This gives exactly WIDTH shifts, with no wrap.
REQ-018 On the OUT edge, q_bcd and r_bcd SHALL load from the accumulators and bcd_valid SHALL be 1 for that cycle only.
REQ-019 q_bcd and r_bcd SHALL hold their values until the next OUT.
REQ-020 Latency: if the edge is recognised at clock edge N, bcd_valid SHALL be high in the cycle following edge N+WIDTH+1.
- With WIDTH=8: valid follows edge N+9.
REQ-021 busy SHALL be 1 in SHIFT and OUT and 0 in IDLE.
REQ-022 A rising edge of done recognised while not in IDLE SHALL be ignored, not queued; done_d still updates.
REQ-023 Quotient/remainder changes after latching SHALL NOT affect the conversion in progress.
REQ-024 Each output nibble SHALL be in the range 0-9; no digit overflow exists for legal parameters.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately, without a clock, set:
- state=IDLE
- q_bcd=0, r_bcd=0
- bcd_valid=0, busy=0
- counter=0
- accumulators=0
REQ-026 Reset SHALL set done_d=1, so a done already high at reset release does not start a conversion.
REQ-027 Reset asserted during SHIFT or OUT SHALL abort the conversion, with no bcd_valid pulse.
REQ-028 After release, the first recognised done rising edge SHALL start a fresh conversion.

Verification
REQ-029 Stimulus: quotient=4, remainder=8, done 0->1 -> q_bcd=12'h004, r_bcd=12'h008, bcd_valid pulses exactly once, 9 cycles after recognition.
REQ-030 Stimulus: quotient=255, remainder=0 -> q_bcd=12'h255, r_bcd=12'h000.
- Then quotient=0, remainder=99 -> q_bcd=12'h000, r_bcd=12'h099.
REQ-031 Stimulus: done held high 40 cycles -> exactly one bcd_valid; busy high for 9 cycles and low afterwards.
REQ-032 Stimulus: done pulses low-high-low, then rises again during SHIFT -> second edge ignored, one bcd_valid.
- After return to IDLE, a new edge converts normally.
REQ-033 Stimulus: rst_n=0 at the 4th SHIFT cycle -> outputs zero immediately, no bcd_valid.
- done high at release -> no conversion until done falls and rises.
REQ-034 Stimulus: exhaustive sweep of quotient/remainder 0..255 -> each BCD result equals its decimal value, checked on every bcd_valid.

Source files
------------

// File: rtl/div_bcd_convert_if.sv
// Divider-result hand-off bus: the upstream divider drives done/quotient/remainder,
// the converter returns packed BCD results with a valid pulse and a busy level.
interface div_bcd_convert_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  done;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  bcd_valid;
  logic                  busy;

  modport master (
    output done, quotient, remainder,
    input  q_bcd, r_bcd, bcd_valid, busy
  );

  modport slave (
    input  done, quotient, remainder,
    output q_bcd, r_bcd, bcd_valid, busy
  );
endinterface

// File: rtl/div_bcd_convert.sv
// Binary-to-BCD converter for a divider's quotient and remainder.
// Both operands run through a double-dabble shifter in parallel, one bit per
// cycle, started by a rising edge of the divider's done level.
module div_bcd_convert #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic              clk,
  input logic              rst_n,
  div_bcd_convert_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t           state;
  logic             done_d;
  logic             rise;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_r;
  logic [BW-1:0]    acc_q;
  logic [BW-1:0]    acc_r;
  logic [BW-1:0]    adj_q;
  logic [BW-1:0]    adj_r;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    q_bcd;
  logic [BW-1:0]    r_bcd;
  logic             bcd_valid;
  logic             busy;

  // Add 3 to every nibble of 5 or more so the following shift carries correctly.
  function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign rise = bus.done & ~done_d;

  // Nibble correction for the current step of both accumulators.
  always_comb begin
    adj_q = dabble_adj(acc_q);
    adj_r = dabble_adj(acc_r);
  end

  // Control FSM, shift datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done_d    <= 1'b1;
      sr_q      <= '0;
      sr_r      <= '0;
      acc_q     <= '0;
      acc_r     <= '0;
      cnt       <= '0;
      q_bcd     <= '0;
      r_bcd     <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done_d    <= bus.done;
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            sr_q  <= bus.quotient;
            sr_r  <= bus.remainder;
            acc_q <= '0;
            acc_r <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= {adj_q[BW-2:0], sr_q[WIDTH-1]};
          acc_r <= {adj_r[BW-2:0], sr_r[WIDTH-1]};
          sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
          sr_r  <= {sr_r[WIDTH-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= OUT;
        end
        OUT: begin
          q_bcd     <= acc_q;
          r_bcd     <= acc_r;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q_bcd     = q_bcd;
  assign bus.r_bcd     = r_bcd;
  assign bus.bcd_valid = bcd_valid;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_div_bcd_convert.sv
// Directed bench for div_bcd_convert (WIDTH=8, DIGITS=3).
module tb_div_bcd_convert;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  div_bcd_convert_if #(.WIDTH(8), .DIGITS(3)) bus ();

  div_bcd_convert #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits by division, independent of the shift-and-add method.
  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until bcd_valid is seen; lat is the number of edges from done rising.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.bcd_valid !== 1'b1 && lat < 40);
  endtask

  task automatic convert(input logic [7:0] q, input logic [7:0] r, output int lat);
    bus.quotient  = q;
    bus.remainder = r;
    bus.done      = 1'b1;
    wait_valid(lat);
  endtask

  initial begin
    int lat;
    int nv;
    int nb;
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    bus.done = 1'b0;
    bus.quotient = '0;
    bus.remainder = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_q_bcd", 32'(bus.q_bcd), 32'h000);
    check("rst_r_bcd", 32'(bus.r_bcd), 32'h000);
    check("rst_valid", 32'(bus.bcd_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 4 / 8 with latency
    convert(8'd4, 8'd8, lat);
    check("lat_4_8", 32'(lat), 32'd10);
    check("q_4", 32'(bus.q_bcd), 32'h004);
    check("r_8", 32'(bus.r_bcd), 32'h008);
    bus.done = 1'b0;
    tick();
    check("valid_one_cycle", 32'(bus.bcd_valid), 32'd0);
    check("hold_q_4", 32'(bus.q_bcd), 32'h004);

    // Extremes
    convert(8'd255, 8'd0, lat);
    check("q_255", 32'(bus.q_bcd), 32'h255);
    check("r_0", 32'(bus.r_bcd), 32'h000);
    bus.done = 1'b0;
    tick();
    convert(8'd0, 8'd99, lat);
    check("q_0", 32'(bus.q_bcd), 32'h000);
    check("r_99", 32'(bus.r_bcd), 32'h099);
    bus.done = 1'b0;
    tick();

    // done held high for 40 cycles
    bus.quotient = 8'd37;
    bus.remainder = 8'd210;
    bus.done = 1'b1;
    nv = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.bcd_valid === 1'b1) nv++;
      if (bus.busy === 1'b1) nb++;
    end
    check("held_valid_count", 32'(nv), 32'd1);
    check("held_busy_cycles", 32'(nb), 32'd9);
    check("held_busy_end", 32'(bus.busy), 32'd0);
    check("held_q_37", 32'(bus.q_bcd), 32'h037);
    check("held_r_210", 32'(bus.r_bcd), 32'h210);
    bus.done = 1'b0;
    tick();

    // Second rising edge during SHIFT is ignored; input changes after latch have no effect
    bus.quotient = 8'd61;
    bus.remainder = 8'd150;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.quotient = 8'd222;
    bus.remainder = 8'd111;
    tick();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.bcd_valid === 1'b1) nv++;
    end
    check("ignored_edge_valid_count", 32'(nv), 32'd1);
    check("ignored_edge_q_61", 32'(bus.q_bcd), 32'h061);
    check("ignored_edge_r_150", 32'(bus.r_bcd), 32'h150);
    convert(8'd200, 8'd9, lat);
    check("after_ignore_lat", 32'(lat), 32'd10);
    check("after_ignore_q_200", 32'(bus.q_bcd), 32'h200);
    check("after_ignore_r_9", 32'(bus.r_bcd), 32'h009);
    bus.done = 1'b0;
    tick();

    // Reset in the 4th SHIFT cycle
    bus.quotient = 8'd123;
    bus.remainder = 8'd45;
    bus.done = 1'b1;
    repeat (4) tick();
    check("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_q_bcd", 32'(bus.q_bcd), 32'h000);
    check("abort_r_bcd", 32'(bus.r_bcd), 32'h000);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.bcd_valid), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    nv = 0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.bcd_valid === 1'b1) nv++;
      if (bus.busy === 1'b1) nb++;
    end
    check("release_high_valid_count", 32'(nv), 32'd0);
    check("release_high_busy_cycles", 32'(nb), 32'd0);
    bus.done = 1'b0;
    tick();
    convert(8'd7, 8'd200, lat);
    check("post_reset_lat", 32'(lat), 32'd10);
    check("post_reset_q_7", 32'(bus.q_bcd), 32'h007);
    check("post_reset_r_200", 32'(bus.r_bcd), 32'h200);
    bus.done = 1'b0;
    tick();

    // Sweep every operand value
    for (int i = 0; i < 256; i++) begin
      convert(8'(i), 8'(255 - i), lat);
      check("sweep_q", 32'(bus.q_bcd), 32'(to_bcd(i)));
      check("sweep_r", 32'(bus.r_bcd), 32'(to_bcd(255 - i)));
      bus.done = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
